flash_array_ctrl: RTL and testbench

- Digital sequencer that drives the control pins of the 8x8 flash array macro and captures its sense-amp outputs.
- Accepts READ, PROGRAM and ERASE commands over a valid/ready request channel.
- Generates timed SSL/GSL/WL/SL/VBPW/sense-enable waveforms and the bit-line drive, and returns read data over a valid/ready response channel.
- Sits between the Wishbone/logic-analyzer glue in user_project_wrapper and the array macro.

---
 rtl/flash_array_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_flash_array_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_array_ctrl.sv
// flash_array_ctrl: sequencer for the 8x8 flash array macro.
// It accepts READ / PROGRAM / ERASE commands on a valid/ready channel and
// drives the timed select, wordline, well-bias and sense-amp waveforms.
// READ data comes back on a valid/ready response channel.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op     command channel (00 NOP, 01 READ, 10 PROG, 11 ERASE)
//   cmd_blk, cmd_wl, cmd_wdata  address and program data, latched at acceptance
//   rsp_valid/ready, rsp_rdata  read response channel
//   busy                        high whenever the sequencer is not idle
//   ssl, gsl, wl0, wl1, sl,     array control lines
//   vbpw, sen1, sen2, out_en
//   arr_out                     sense-amp outputs from the array
//   bl_data, bl_oe              bit-line drive
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_SETUP   | select/WL levels settle before sense or pulse
// S_PRE     | sense-amp precharge (sen1)
// S_SENSE   | sense-amp evaluate (sen2)
// S_CAPTURE | output enables on, arr_out latched at the end
// S_RESP    | read data offered, waits for rsp_ready
// S_PROG    | program pulse on the addressed wordline
// S_ERASE   | erase pulse, P-well and source line biased
// S_RECOVER | all lines low before returning to idle
//
// Every output is registered from the next-state decode, so the output
// levels line up with the state register rather than lagging it.
module flash_array_ctrl #(
  parameter int T_SETUP = 4,
  parameter int T_PRE   = 4,
  parameter int T_SENSE = 8,
  parameter int T_PROG  = 64,
  parameter int T_ERASE = 256,
  parameter int CNT_W   = 9
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_blk,
  input  logic [1:0] cmd_wl,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] ssl,
  output logic [1:0] gsl,
  output logic [3:0] wl0,
  output logic [3:0] wl1,
  output logic       sl,
  output logic       vbpw,
  output logic       sen1,
  output logic       sen2,
  output logic [3:0] out_en,
  input  logic [7:0] arr_out,
  output logic [7:0] bl_data,
  output logic       bl_oe
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PRE, S_SENSE, S_CAPTURE, S_RESP, S_PROG, S_ERASE, S_RECOVER
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_PROG = 2'b10;

  localparam logic [CNT_W-1:0] LAST_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LAST_PRE   = CNT_W'(T_PRE - 1);
  localparam logic [CNT_W-1:0] LAST_SENSE = CNT_W'(T_SENSE - 1);
  localparam logic [CNT_W-1:0] LAST_PROG  = CNT_W'(T_PROG - 1);
  localparam logic [CNT_W-1:0] LAST_ERASE = CNT_W'(T_ERASE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             blk_q, blk_d;
  logic [1:0]       wl_q, wl_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;

  logic       cmd_ready_q, busy_q, rsp_valid_q;
  logic [1:0] ssl_q, ssl_d, gsl_q, gsl_d;
  logic [3:0] wl0_q, wl0_d, wl1_q, wl1_d, out_en_q, out_en_d;
  logic       sl_q, sl_d, vbpw_q, vbpw_d, sen1_q, sen1_d, sen2_q, sen2_d;
  logic [7:0] bl_data_q, bl_data_d;
  logic       bl_oe_q, bl_oe_d;

  logic [3:0] wl_sel;
  logic       read_ph, prog_ph, erase_ph;

  // Next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    op_d    = op_q;
    blk_d   = blk_q;
    wl_d    = wl_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // cmd_ready is high exactly in IDLE, so cmd_valid alone is the handshake
        if (cmd_valid) begin
          op_d    = cmd_op;
          blk_d   = cmd_blk;
          wl_d    = cmd_wl;
          wdata_d = cmd_wdata;
          if (cmd_op != OP_NOP) state_d = S_SETUP;
        end
      end
      S_SETUP: if (cnt_q == LAST_SETUP) begin
        cnt_d = '0;
        if (op_q == OP_READ)      state_d = S_PRE;
        else if (op_q == OP_PROG) state_d = S_PROG;
        else                      state_d = S_ERASE;
      end
      S_PRE:     if (cnt_q == LAST_PRE)   begin cnt_d = '0; state_d = S_SENSE;   end
      S_SENSE:   if (cnt_q == LAST_SENSE) begin cnt_d = '0; state_d = S_CAPTURE; end
      S_CAPTURE: begin
        cnt_d   = '0;
        rdata_d = arr_out;
        state_d = S_RESP;
      end
      S_RESP: begin
        cnt_d = '0;
        if (rsp_ready) state_d = S_IDLE;
      end
      S_PROG:    if (cnt_q == LAST_PROG)  begin cnt_d = '0; state_d = S_RECOVER; end
      S_ERASE:   if (cnt_q == LAST_ERASE) begin cnt_d = '0; state_d = S_RECOVER; end
      S_RECOVER: if (cnt_q == LAST_SETUP) begin cnt_d = '0; state_d = S_IDLE;    end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Array line decode for the upcoming state
  always_comb begin
    ssl_d     = '0;
    gsl_d     = '0;
    wl0_d     = '0;
    wl1_d     = '0;
    sl_d      = 1'b0;
    vbpw_d    = 1'b0;
    sen1_d    = 1'b0;
    sen2_d    = 1'b0;
    out_en_d  = '0;
    bl_data_d = '0;
    bl_oe_d   = 1'b0;
    wl_sel    = 4'(1) << wl_d;
    read_ph   = (state_d == S_PRE) || (state_d == S_SENSE) || (state_d == S_CAPTURE) ||
                ((state_d == S_SETUP) && (op_d == OP_READ));
    prog_ph   = (state_d == S_PROG) || ((state_d == S_SETUP) && (op_d == OP_PROG));
    erase_ph  = (state_d == S_ERASE) ||
                ((state_d == S_SETUP) && (op_d != OP_READ) && (op_d != OP_PROG));
    if (read_ph) begin
      ssl_d[blk_d] = 1'b1;
      gsl_d[blk_d] = 1'b1;
      // pass voltage on every wordline of the block except the one being read
      if (blk_d) wl1_d = ~wl_sel;
      else       wl0_d = ~wl_sel;
      sen1_d   = (state_d == S_PRE);
      sen2_d   = (state_d == S_SENSE);
      out_en_d = (state_d == S_CAPTURE) ? 4'hF : 4'h0;
    end
    if (prog_ph) begin
      ssl_d[blk_d] = 1'b1;
      bl_oe_d      = 1'b1;
      bl_data_d    = ~wdata_d;  // 0 V on a bit line programs that cell
      if (state_d == S_PROG) begin
        if (blk_d) wl1_d = wl_sel;
        else       wl0_d = wl_sel;
      end
    end
    if (erase_ph) begin
      // unselected block wordlines high to inhibit erase there
      if (blk_d) wl0_d = 4'hF;
      else       wl1_d = 4'hF;
      vbpw_d = (state_d == S_ERASE);
      sl_d   = (state_d == S_ERASE);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      blk_q       <= 1'b0;
      wl_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      ssl_q       <= '0;
      gsl_q       <= '0;
      wl0_q       <= '0;
      wl1_q       <= '0;
      sl_q        <= 1'b0;
      vbpw_q      <= 1'b0;
      sen1_q      <= 1'b0;
      sen2_q      <= 1'b0;
      out_en_q    <= '0;
      bl_data_q   <= '0;
      bl_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      blk_q       <= blk_d;
      wl_q        <= wl_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      ssl_q       <= ssl_d;
      gsl_q       <= gsl_d;
      wl0_q       <= wl0_d;
      wl1_q       <= wl1_d;
      sl_q        <= sl_d;
      vbpw_q      <= vbpw_d;
      sen1_q      <= sen1_d;
      sen2_q      <= sen2_d;
      out_en_q    <= out_en_d;
      bl_data_q   <= bl_data_d;
      bl_oe_q     <= bl_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ssl       = ssl_q;
  assign gsl       = gsl_q;
  assign wl0       = wl0_q;
  assign wl1       = wl1_q;
  assign sl        = sl_q;
  assign vbpw      = vbpw_q;
  assign sen1      = sen1_q;
  assign sen2      = sen2_q;
  assign out_en    = out_en_q;
  assign bl_data   = bl_data_q;
  assign bl_oe     = bl_oe_q;

endmodule

// File: tb/tb_flash_array_ctrl.sv
// Directed bench for flash_array_ctrl. Cycle k is sampled on the falling
// edge k cycles after the rising edge that accepted the command.
module tb_flash_array_ctrl;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_blk;
  logic [1:0] cmd_wl;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [1:0] ssl, gsl;
  logic [3:0] wl0, wl1, out_en;
  logic       sl, vbpw, sen1, sen2;
  logic [7:0] arr_out, bl_data;
  logic       bl_oe;

  int nerr = 0;
  int nchk = 0;
  int cnt_hi;

  flash_array_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_blk(cmd_blk), .cmd_wl(cmd_wl), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .ssl(ssl), .gsl(gsl), .wl0(wl0), .wl1(wl1), .sl(sl),
    .vbpw(vbpw), .sen1(sen1), .sen2(sen2), .out_en(out_en),
    .arr_out(arr_out), .bl_data(bl_data), .bl_oe(bl_oe)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // {ssl, gsl, wl0, wl1, sl, vbpw, sen1, sen2, out_en, bl_oe, bl_data}
  function automatic logic [31:0] mk(input logic [1:0] e_ssl, input logic [1:0] e_gsl,
                                     input logic [3:0] e_wl0, input logic [3:0] e_wl1,
                                     input logic e_sl, input logic e_vbpw,
                                     input logic e_sen1, input logic e_sen2,
                                     input logic [3:0] e_oe, input logic e_bloe,
                                     input logic [7:0] e_bld);
    return {3'b000, e_ssl, e_gsl, e_wl0, e_wl1, e_sl, e_vbpw, e_sen1, e_sen2, e_oe, e_bloe, e_bld};
  endfunction

  function automatic logic [31:0] obs_arr();
    return {3'b000, ssl, gsl, wl0, wl1, sl, vbpw, sen1, sen2, out_en, bl_oe, bl_data};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic issue(input logic [1:0] op, input logic blk, input logic [1:0] wl,
                       input logic [7:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_blk   = blk;
    cmd_wl    = wl;
    cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] rd_exp(input int k, input logic [1:0] sel, input logic [3:0] w);
    return mk(sel, sel, w, 4'h0, 1'b0, 1'b0, (k >= 5 && k <= 8), (k >= 9 && k <= 16),
              (k == 17) ? 4'hF : 4'h0, 1'b0, 8'h00);
  endfunction

  initial begin
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_blk = 1'b0;
    cmd_wl = 2'b00; cmd_wdata = 8'h00; rsp_ready = 1'b1; arr_out = 8'h00;
    @(negedge wb_clk_i);
    step();
    step();
    check("rst_arr", obs_arr(), 32'h0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'h0);
    wb_rst_i = 1'b0;
    step();

    // NOP leaves the block idle
    issue(2'b00, 1'b0, 2'd0, 8'h00);
    check("nop_busy", {31'b0, busy}, 32'd0);
    check("nop_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("nop_arr", obs_arr(), 32'h0);

    // READ blk0 wl2, response taken immediately
    arr_out = 8'hA5; rsp_ready = 1'b1;
    issue(2'b01, 1'b0, 2'd2, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("rd0_arr_c%0d", k), obs_arr(), rd_exp(k, 2'b01, 4'b1011));
      check($sformatf("rd0_rsp_valid_c%0d", k), {31'b0, rsp_valid}, 32'd0);
      check($sformatf("rd0_cmd_ready_c%0d", k), {31'b0, cmd_ready}, 32'd0);
      step();
    end
    check("rd0_rsp_valid_c18", {31'b0, rsp_valid}, 32'd1);
    check("rd0_rdata_c18", {24'b0, rsp_rdata}, 32'hA5);
    check("rd0_arr_c18", obs_arr(), 32'h0);
    check("rd0_busy_c18", {31'b0, busy}, 32'd1);
    step();
    check("rd0_rsp_valid_c19", {31'b0, rsp_valid}, 32'd0);
    check("rd0_busy_c19", {31'b0, busy}, 32'd0);
    check("rd0_cmd_ready_c19", {31'b0, cmd_ready}, 32'd1);

    // READ blk1 wl0 with response back-pressure
    arr_out = 8'h3C; rsp_ready = 1'b0;
    issue(2'b01, 1'b1, 2'd0, 8'h00);
    check("rd1_arr_c1", obs_arr(),
          mk(2'b10, 2'b10, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00));
    for (int k = 1; k < 18; k++) step();
    arr_out = 8'h00;
    for (int k = 18; k <= 22; k++) begin
      check($sformatf("rd1_rsp_valid_c%0d", k), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("rd1_rdata_c%0d", k), {24'b0, rsp_rdata}, 32'h3C);
      step();
    end
    check("rd1_rsp_valid_c23", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    step();
    check("rd1_rsp_valid_c24", {31'b0, rsp_valid}, 32'd0);
    check("rd1_rdata_hold_c24", {24'b0, rsp_rdata}, 32'h3C);
    check("rd1_cmd_ready_c24", {31'b0, cmd_ready}, 32'd1);

    // PROGRAM blk1 wl1, data F0
    issue(2'b10, 1'b1, 2'd1, 8'hF0);
    cnt_hi = 0;
    for (int k = 1; k <= 73; k++) begin
      logic [31:0] e;
      if (k <= 4)       e = mk(2'b10, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h0F);
      else if (k <= 68) e = mk(2'b10, 2'b00, 4'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h0F);
      else              e = 32'h0;
      check($sformatf("pg_arr_c%0d", k), obs_arr(), e);
      check($sformatf("pg_busy_c%0d", k), {31'b0, busy}, {31'b0, k <= 72});
      check($sformatf("pg_cmd_ready_c%0d", k), {31'b0, cmd_ready}, {31'b0, k > 72});
      if (wl1 == 4'b0010) cnt_hi++;
      if (k < 73) step();
    end
    check("pg_wl_pulse_len", cnt_hi, 32'd64);

    // ERASE blk0
    issue(2'b11, 1'b0, 2'd0, 8'h00);
    cnt_hi = 0;
    for (int k = 1; k <= 265; k++) begin
      logic [31:0] e;
      if (k <= 4)        e = mk(2'b00, 2'b00, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      else if (k <= 260) e = mk(2'b00, 2'b00, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
      else               e = 32'h0;
      check($sformatf("er_arr_c%0d", k), obs_arr(), e);
      check($sformatf("er_busy_c%0d", k), {31'b0, busy}, {31'b0, k <= 264});
      if (vbpw) cnt_hi++;
      if (k < 265) step();
    end
    check("er_pulse_len", cnt_hi, 32'd256);

    // Back-to-back: READ then PROGRAM with cmd_valid held high
    arr_out = 8'h5A; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_blk = 1'b0; cmd_wl = 2'd3; cmd_wdata = 8'h00;
    step();
    cmd_op = 2'b10; cmd_blk = 1'b1; cmd_wl = 2'd2; cmd_wdata = 8'h81;
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("bb_rd_arr_c%0d", k), obs_arr(), rd_exp(k, 2'b01, 4'b0111));
      check($sformatf("bb_cmd_ready_c%0d", k), {31'b0, cmd_ready}, 32'd0);
      step();
    end
    check("bb_rsp_valid_c18", {31'b0, rsp_valid}, 32'd1);
    check("bb_rdata_c18", {24'b0, rsp_rdata}, 32'h5A);
    check("bb_cmd_ready_c18", {31'b0, cmd_ready}, 32'd0);
    step();
    check("bb_cmd_ready_c19", {31'b0, cmd_ready}, 32'd1);
    check("bb_busy_c19", {31'b0, busy}, 32'd0);
    step();
    cmd_valid = 1'b0; cmd_wdata = 8'hFF;
    check("bb_busy_c20", {31'b0, busy}, 32'd1);
    check("bb_pg_setup_c20", obs_arr(),
          mk(2'b10, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h7E));
    step();
    check("bb_pg_setup_c21", obs_arr(),
          mk(2'b10, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h7E));
    for (int k = 21; k < 24; k++) step();
    check("bb_pg_pulse_c24", obs_arr(),
          mk(2'b10, 2'b00, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h7E));
    for (int k = 24; k < 29; k++) step();
    check("bb_pg_pulse_c29", obs_arr(),
          mk(2'b10, 2'b00, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h7E));

    // Reset at PROG cycle 10 of that command aborts it
    wb_rst_i = 1'b1;
    step();
    check("abort_arr", obs_arr(), 32'h0);
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_rsp_rdata", {24'b0, rsp_rdata}, 32'h0);
    wb_rst_i = 1'b0;
    step();
    step();
    check("abort_stays_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
